// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder: prefix tracking, modifiers, typematic filter,
// press counter and a first-word-fall-through character FIFO.
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_W    = 8,
  parameter int UPPER_EN   = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [7:0]         scan_data,
  input  logic               scan_valid,
  input  logic               out_ready,
  output logic [7:0]         ascii_data,
  output logic               ascii_valid,
  output logic [7:0]         key_scan,
  output logic               key_pressed,
  output logic               shift_active,
  output logic               caps_lock,
  output logic [COUNT_W-1:0] press_count,
  output logic               overflow
);

  // state   | meaning
  // IDLE    | no prefix pending; next byte is a make or a prefix
  // BRK     | F0 seen; next byte is released
  // EXT     | E0 seen; extended codes are ignored
  // EXT_BRK | E0 F0 seen; next byte ignored
  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t state_q, state_d;
  logic shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic caps_q, caps_d;
  logic [7:0] key_scan_q, key_scan_d;
  logic key_pressed_q, key_pressed_d;
  logic [COUNT_W-1:0] press_count_q, press_count_d;
  logic push_q, push_d;
  logic [7:0] push_char_q, push_char_d;
  logic overflow_q, overflow_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;

  logic make_ev, brk_ev, pop, full, do_push;
  logic [7:0] map_ch;

  function automatic logic [7:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = "a";  8'h32: map_code = "b";  8'h21: map_code = "c";
      8'h23: map_code = "d";  8'h24: map_code = "e";  8'h2B: map_code = "f";
      8'h34: map_code = "g";  8'h33: map_code = "h";  8'h43: map_code = "i";
      8'h3B: map_code = "j";  8'h42: map_code = "k";  8'h4B: map_code = "l";
      8'h3A: map_code = "m";  8'h31: map_code = "n";  8'h44: map_code = "o";
      8'h4D: map_code = "p";  8'h15: map_code = "q";  8'h2D: map_code = "r";
      8'h1B: map_code = "s";  8'h2C: map_code = "t";  8'h3C: map_code = "u";
      8'h2A: map_code = "v";  8'h1D: map_code = "w";  8'h22: map_code = "x";
      8'h35: map_code = "y";  8'h1A: map_code = "z";
      8'h45: map_code = "0";  8'h16: map_code = "1";  8'h1E: map_code = "2";
      8'h26: map_code = "3";  8'h25: map_code = "4";  8'h2E: map_code = "5";
      8'h36: map_code = "6";  8'h3D: map_code = "7";  8'h3E: map_code = "8";
      8'h46: map_code = "9";
      8'h29: map_code = 8'h20;
      8'h5A: map_code = 8'h0D;
      default: map_code = 8'h00;  // no mapped character is NUL
    endcase
  endfunction

  assign map_ch  = map_code(scan_data);
  assign make_ev = scan_valid && (state_q == S_IDLE) && (scan_data != 8'hF0) && (scan_data != 8'hE0);
  assign brk_ev  = scan_valid && (state_q == S_BRK);

  always_comb begin
    state_d       = state_q;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    caps_d        = caps_q;
    key_scan_d    = key_scan_q;
    key_pressed_d = key_pressed_q;
    press_count_d = press_count_q;
    push_d        = 1'b0;
    push_char_d   = push_char_q;

    if (scan_valid) begin
      case (state_q)
        S_IDLE:    state_d = (scan_data == 8'hF0) ? S_BRK :
                             (scan_data == 8'hE0) ? S_EXT : S_IDLE;
        S_EXT:     state_d = (scan_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    if (make_ev) begin
      if (scan_data == 8'h12) begin
        shift_l_d = 1'b1;
      end else if (scan_data == 8'h59) begin
        shift_r_d = 1'b1;
      end else if (!(key_pressed_q && (key_scan_q == scan_data))) begin
        key_scan_d    = scan_data;
        key_pressed_d = 1'b1;
        if (scan_data == 8'h58) caps_d = ~caps_q;
        if (map_ch != 8'h00) begin
          press_count_d = press_count_q + COUNT_W'(1);
          push_d        = 1'b1;
          push_char_d   = map_ch;
          if ((UPPER_EN != 0) && ((shift_l_q | shift_r_q) ^ caps_q) &&
              (map_ch >= "a") && (map_ch <= "z"))
            push_char_d = map_ch - 8'h20;
        end
      end
    end

    if (brk_ev) begin
      if (scan_data == 8'h12) shift_l_d = 1'b0;
      if (scan_data == 8'h59) shift_r_d = 1'b0;
      if (scan_data == key_scan_q) key_pressed_d = 1'b0;
    end
  end

  // The decoded character is registered once before entering the FIFO.
  assign pop        = (count_q != '0) && out_ready;
  assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_push    = push_q && (!full || pop);
  assign overflow_d = overflow_q | (push_q && full && !pop);
  assign rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      caps_q        <= 1'b0;
      key_scan_q    <= 8'h00;
      key_pressed_q <= 1'b0;
      press_count_q <= '0;
      push_q        <= 1'b0;
      push_char_q   <= 8'h00;
      overflow_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      caps_q        <= caps_d;
      key_scan_q    <= key_scan_d;
      key_pressed_q <= key_pressed_d;
      press_count_q <= press_count_d;
      push_q        <= push_d;
      push_char_q   <= push_char_d;
      overflow_q    <= overflow_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn && do_push) mem[wr_ptr_q] <= push_char_q;
  end

  assign ascii_valid  = (count_q != '0);
  assign ascii_data   = ascii_valid ? mem[rd_ptr_q] : 8'h00;
  assign key_scan     = key_scan_q;
  assign key_pressed  = key_pressed_q;
  assign shift_active = shift_l_q | shift_r_q;
  assign caps_lock    = caps_q;
  assign press_count  = press_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench: directed scenarios plus random scan-code streams against a
// transaction-level keyboard model.
module tb_ps2_ascii_decoder;
  logic clk = 1'b0;
  logic clrn, scan_valid, out_ready;
  logic [7:0] scan_data, ascii_data, key_scan, press_count;
  logic ascii_valid, key_pressed, shift_active, caps_lock, overflow;

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .COUNT_W(8), .UPPER_EN(1)) dut (
    .clk(clk), .clrn(clrn), .scan_data(scan_data), .scan_valid(scan_valid),
    .out_ready(out_ready), .ascii_data(ascii_data), .ascii_valid(ascii_valid),
    .key_scan(key_scan), .key_pressed(key_pressed), .shift_active(shift_active),
    .caps_lock(caps_lock), .press_count(press_count), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  logic [7:0] codes [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};

  // keyboard model
  bit m_brk, m_ext, m_shl, m_shr, m_caps, m_held_v, m_ovf;
  logic [7:0] m_held;
  int m_presses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(input logic [7:0] c);
    string s = "abcdefghijklmnopqrstuvwxyz0123456789";
    for (int i = 0; i < 36; i++) if (codes[i] == c) return s[i];
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    {m_brk, m_ext, m_shl, m_shr, m_caps, m_held_v, m_ovf} = '0;
    m_held = 8'h00;
    m_presses = 0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] ch;
    if (m_ext) begin
      if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12) m_shl = 0;
      if (b == 8'h59) m_shr = 0;
      if (b == m_held) m_held_v = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'h12) m_shl = 1;
    else if (b == 8'h59) m_shr = 1;
    else if (!(m_held_v && m_held == b)) begin
      if (b == 8'h58) m_caps = !m_caps;
      m_held = b;
      m_held_v = 1;
      ch = ref_char(b);
      if (ch != 0) begin
        m_presses++;
        if (((m_shl || m_shr) != m_caps) && ch >= "a" && ch <= "z") ch = ch - 8'd32;
        exp_q.push_back(ch);
      end
    end
  endtask

  always @(negedge clk) begin
    if (clrn === 1'b1 && ascii_valid && out_ready) begin
      rx_q.push_back(ascii_data);
      if (exp_q.size() == 0) check("spurious_char", 32'(ascii_data), 32'h100);
      else check("char", 32'(ascii_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key_scan"}, 32'(key_scan), 32'(m_held));
    check({tag, "_key_pressed"}, 32'(key_pressed), 32'(m_held_v));
    check({tag, "_shift"}, 32'(shift_active), 32'(m_shl | m_shr));
    check({tag, "_caps"}, 32'(caps_lock), 32'(m_caps));
    check({tag, "_count"}, 32'(press_count), 32'(m_presses % 256));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b, input bit chk_each);
    scan_data = b;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    model_byte(b);
    @(negedge clk);
    if (chk_each) check_state("byte");
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    @(negedge clk);
    model_reset();
    check("rst_valid", 32'(ascii_valid), 0);
    check("rst_data", 32'(ascii_data), 0);
    check_state("rst");
    @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic drain();
    rnd_ready = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 0);
    check("drain_empty", 32'(ascii_valid), 0);
  endtask

  initial begin
    logic [7:0] b, last;
    logic [7:0] t5 [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    clrn = 1'b0; scan_valid = 1'b0; scan_data = 8'h00; out_ready = 1'b1;
    model_reset();
    tick();

    // 1: single press/release
    do_reset();
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
    drain();
    check("t1_nrx", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) check("t1_char", 32'(rx_q[0]), 32'h61);
    check("t1_count", 32'(press_count), 1);
    check("t1_pressed", 32'(key_pressed), 0);
    check("t1_scan", 32'(key_scan), 32'h1C);

    // 2: typematic repeats
    do_reset();
    foreach (t5[i]) if (i < 3) send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 1);
    drain();
    check("t2_nrx", 32'(rx_q.size()), 1);
    check("t2_count", 32'(press_count), 1);

    // 3: shift and caps lock
    do_reset();
    send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h12, 1);
    send(8'h58, 1); send(8'hF0, 1); send(8'h58, 1); send(8'h32, 1);
    drain();
    check("t3_nrx", 32'(rx_q.size()), 2);
    if (rx_q.size() > 1) begin
      check("t3_c0", 32'(rx_q[0]), 32'h41);
      check("t3_c1", 32'(rx_q[1]), 32'h42);
    end
    check("t3_caps", 32'(caps_lock), 1);
    check("t3_shift", 32'(shift_active), 0);

    // 4: extended and unmapped codes
    do_reset();
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); send(8'h0E, 1);
    drain();
    check("t4_nrx", 32'(rx_q.size()), 0);
    check("t4_count", 32'(press_count), 0);
    check("t4_scan", 32'(key_scan), 32'h0E);
    check("t4_pressed", 32'(key_pressed), 1);

    // 5: FIFO overflow, ninth character dropped
    do_reset();
    out_ready = 1'b0;
    foreach (t5[i]) begin send(t5[i], 0); send(8'hF0, 0); send(t5[i], 0); end
    tick(); tick();
    @(negedge clk);
    void'(exp_q.pop_back());
    m_ovf = 1;
    check("t5_valid", 32'(ascii_valid), 1);
    check("t5_overflow", 32'(overflow), 1);
    check("t5_count", 32'(press_count), 9);
    drain();
    check("t5_nrx", 32'(rx_q.size()), 8);
    foreach (rx_q[i]) check("t5_order", 32'(rx_q[i]), 32'(ref_char(t5[i])));

    // 6: reset while a break prefix is pending
    do_reset();
    send(8'hF0, 1);
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    model_reset();
    send(8'h1C, 1);
    drain();
    check("t6_nrx", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) check("t6_char", 32'(rx_q[0]), 32'h61);
    check("t6_scan", 32'(key_scan), 32'h1C);
    check("t6_caps", 32'(caps_lock), 0);
    check("t6_count", 32'(press_count), 1);

    // random streams with random consumer back-pressure
    do_reset();
    rnd_ready = 1;
    last = 8'h1C;
    for (int n = 0; n < 500; n++) begin
      int r = $urandom_range(0, 99);
      int budget = 0;
      while (exp_q.size() >= 5 && budget < 200) begin tick(); budget++; end
      if (budget >= 200) check("rnd_stall", 32'(exp_q.size()), 0);
      if (r < 40) b = (r < 36) ? codes[$urandom_range(0, 35)] : ((r & 1) ? 8'h29 : 8'h5A);
      else if (r < 56) b = 8'hF0;
      else if (r < 62) b = 8'hE0;
      else if (r < 72) b = (r & 1) ? 8'h12 : 8'h59;
      else if (r < 78) b = 8'h58;
      else if (r < 86) b = 8'($urandom_range(0, 255));
      else b = last;
      last = b;
      rnd_ready = 1;
      send(b, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    check_state("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
